// File: rtl/four_bank_mem_resp.sv
// four_bank_mem_resp: single-ported memory split into 4 word-interleaved banks with per-bank
// busy timers and a fixed-latency read pipeline. Define MEM_ALIGN_CHECK_EN to reject odd addresses.
module four_bank_mem_resp #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MEM_WORDS = 2048,
  parameter int BANK_LAT  = 4,
  parameter int RD_LAT    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          stall,
  output logic [3:0]    busy,
  output logic          err
);

  localparam int CW = $clog2(BANK_LAT + 1);
  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic          req;
  logic          illegal;
  logic          misaligned;
  logic          accept;
  logic [1:0]    bank;
  logic [IW-1:0] wordIdx;

  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;
  logic [DW-1:0]     dat_q [RD_LAT];
  logic [DW-1:0]     dat_d [RD_LAT];

  logic [DW-1:0] mem [MEM_WORDS];

  assign req  = rd | wr;
  assign bank = addr[2:1];

  // Word index wraps modulo the storage depth; out-of-range addresses are legal aliases.
  assign wordIdx = IW'(32'(addr[AW-1:1]) % MEM_WORDS);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = addr[0];
`else
  logic unusedAddrLsb;
  assign unusedAddrLsb = addr[0];
  assign misaligned    = 1'b0;
`endif

  assign illegal = (rd & wr) | misaligned;
  assign err     = req & illegal;
  assign stall   = req & ~illegal & busy[bank];
  assign accept  = req & ~illegal & ~busy[bank];

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      busy[b] = (cnt_q[b] != '0);
    end
  end

  // A fresh accept reloads its bank's timer; every other running timer counts down to zero.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      cnt_d[b] = (cnt_q[b] != '0) ? (cnt_q[b] - CW'(1)) : '0;
      if (accept && (bank == 2'(b))) begin
        cnt_d[b] = CW'(BANK_LAT);
      end
    end
  end

  always_comb begin
    vld_d[0] = accept & rd;
    dat_d[0] = (accept & rd) ? mem[wordIdx] : '0;
    for (int s = 1; s < RD_LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      dat_d[s] = dat_q[s-1];
    end
  end

  assign data_out = vld_q[RD_LAT-1] ? dat_q[RD_LAT-1] : '0;

  // Reset flushes in-flight reads so their data never reaches data_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        cnt_q[b] <= '0;
      end
      vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        dat_q[s] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
      vld_q <= vld_d;
      for (int s = 0; s < RD_LAT; s++) begin
        dat_q[s] <= dat_d[s];
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[wordIdx] <= data_in;
    end
  end

endmodule

// File: tb/tb_four_bank_mem_resp.sv
// Testbench for four_bank_mem_resp: directed scenarios plus random traffic checked against
// a timestamp-based behavioural model of bank occupancy, storage and read return.
module tb_four_bank_mem_resp;

  localparam int AW        = 16;
  localparam int DW        = 16;
  localparam int MEM_WORDS = 2048;
  localparam int BANK_LAT  = 4;
  localparam int RD_LAT    = 2;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          stall;
  logic [3:0]    busy;
  logic          err;

  four_bank_mem_resp #(
    .AW(AW), .DW(DW), .MEM_WORDS(MEM_WORDS), .BANK_LAT(BANK_LAT), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .stall(stall), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state: a bank is busy while the cycle count is below its free time.
  int          freeAt [4];
  logic [15:0] modelMem [MEM_WORDS];
  logic [15:0] dueData [int];

  logic [15:0] lastData;
  logic [3:0]  lastBusy;
  logic        lastStall;
  logic        lastErr;
  bit          lastAcc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One cycle: drive a request, compare all outputs against the model, then commit it.
  task automatic applyStimulus(input logic r, input logic w, input logic [15:0] a,
                               input logic [15:0] d);
    int          b;
    int          idx;
    bit          isReq;
    bit          isIllegal;
    bit          expErr;
    bit          expStall;
    bit          expAcc;
    logic [3:0]  expBusy;
    logic [15:0] expData;
    rd = r; wr = w; addr = a; data_in = d;
    @(negedge clk);
    b   = (int'(a) >> 1) % 4;
    idx = (int'(a) >> 1) % MEM_WORDS;
    for (int i = 0; i < 4; i++) expBusy[i] = (cyc < freeAt[i]);
    isReq     = r || w;
    isIllegal = (r && w) || (ALIGN && a[0]);
    expErr    = isReq && isIllegal;
    expStall  = isReq && !isIllegal && expBusy[b];
    expAcc    = isReq && !isIllegal && !expBusy[b];
    expData   = dueData.exists(cyc) ? dueData[cyc] : 16'h0000;
    checkOutput("err", 32'(err), 32'(expErr));
    checkOutput("stall", 32'(stall), 32'(expStall));
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("data_out", 32'(data_out), 32'(expData));
    lastData = data_out; lastBusy = busy; lastStall = stall; lastErr = err; lastAcc = expAcc;
    @(posedge clk);
    if (expAcc) begin
      freeAt[b] = cyc + BANK_LAT + 1;
      if (w) modelMem[idx] = d;
      else   dueData[cyc + RD_LAT] = modelMem[idx];
    end
    if (dueData.exists(cyc)) dueData.delete(cyc);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Holds a request until the model says it is accepted, bounded by a cycle budget.
  task automatic issue(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    int tries = 0;
    do begin
      applyStimulus(r, w, a, d);
      tries++;
    end while (!lastAcc && tries < 20);
    if (!lastAcc) checkOutput("issue_timeout", 32'(tries), 32'(BANK_LAT + 1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] obs [6];
    logic        st  [4];
    int          kind;
    int          word;
    logic [15:0] a;

    for (int i = 0; i < 4; i++) freeAt[i] = 0;
    for (int i = 0; i < MEM_WORDS; i++) modelMem[i] = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_data", 32'(data_out), 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] preloading words 0..63");
    for (int w = 0; w < 64; w++) issue(1'b0, 1'b1, 16'(w * 2), 16'($urandom));

    $display("[TB] write then read back");
    idle(6);
    issue(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    checkOutput("t1_wr_stall", 32'(lastStall), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      checkOutput("t1_busy0", 32'(lastBusy[0]), 32'h1);
    end
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
    checkOutput("t1_rd_stall", 32'(lastStall), 32'h0);
    idle(1);
    checkOutput("t1_data_early", 32'(lastData), 32'h0);
    idle(1);
    checkOutput("t1_data", 32'(lastData), 32'hBEEF);
    idle(1);
    checkOutput("t1_data_late", 32'(lastData), 32'h0);

    $display("[TB] same-bank read stalls");
    issue(1'b0, 1'b1, 16'h0000, 16'hA5A5);
    idle(6);
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
    checkOutput("t2_first_stall", 32'(lastStall), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
      checkOutput("t2_stall", 32'(lastStall), 32'h1);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000);
    checkOutput("t2_second_accept", 32'(lastStall), 32'h0);
    idle(1);
    idle(1);
    checkOutput("t2_data", 32'(lastData), 32'hA5A5);

    $display("[TB] pipelined reads across all banks");
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 16'(i * 2), 16'(16'h3000 + i));
    idle(6);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) applyStimulus(1'b1, 1'b0, 16'(i * 2), 16'h0000);
      else       idle(1);
      obs[i] = lastData;
      if (i < 4) st[i] = lastStall;
      if (i == 4) checkOutput("t3_busy_all", 32'(lastBusy), 32'hF);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_stall", 32'(st[i]), 32'h0);
      checkOutput("t3_data", 32'(obs[i + 2]), 32'(16'h3000 + i));
    end

    $display("[TB] illegal requests");
    issue(1'b0, 1'b1, 16'h0008, 16'h4444);
    issue(1'b0, 1'b1, 16'h0002, 16'h1111);
    idle(6);
    applyStimulus(1'b1, 1'b1, 16'h0008, 16'h5555);
    checkOutput("t4_err", 32'(lastErr), 32'h1);
    checkOutput("t4_stall", 32'(lastStall), 32'h0);
    idle(1);
    checkOutput("t4_busy", 32'(lastBusy), 32'h0);
    issue(1'b1, 1'b0, 16'h0008, 16'h0000);
    idle(2);
    checkOutput("t4_word_kept", 32'(lastData), 32'h4444);
    idle(6);
    applyStimulus(1'b0, 1'b1, 16'h0003, 16'h7777);
    checkOutput("t4_align_err", 32'(lastErr), ALIGN ? 32'h1 : 32'h0);
    idle(6);
    issue(1'b1, 1'b0, 16'h0002, 16'h0000);
    idle(2);
    checkOutput("t4_align_word", 32'(lastData), ALIGN ? 32'h1111 : 32'h7777);

    $display("[TB] reset during an in-flight read");
    issue(1'b0, 1'b1, 16'h0012, 16'h1212);
    idle(6);
    applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0000);
    rd = 1'b0; wr = 1'b0; addr = '0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_busy", 32'(busy), 32'h0);
    checkOutput("t5_rst_data", 32'(data_out), 32'h0);
    dueData.delete();
    for (int i = 0; i < 4; i++) freeAt[i] = 0;
    @(posedge clk);
    cyc++;
    #3;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0000);
    checkOutput("t5_after_stall", 32'(lastStall), 32'h0);
    checkOutput("t5_flushed", 32'(lastData), 32'h0);
    idle(2);
    checkOutput("t5_data", 32'(lastData), 32'h1212);

    $display("[TB] address wrap");
    idle(6);
    issue(1'b0, 1'b1, 16'h1000, 16'h1234);
    issue(1'b1, 1'b0, 16'h0000, 16'h0000);
    idle(2);
    checkOutput("t6_wrap", 32'(lastData), 32'h1234);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 9));
      word = int'($urandom_range(0, 63)) + MEM_WORDS * int'($urandom_range(0, 15));
      a    = 16'(word * 2);
      if ($urandom_range(0, 3) == 0) a[0] = 1'b1;
      if (kind < 2)      applyStimulus(1'b0, 1'b0, a, 16'($urandom));
      else if (kind < 6) applyStimulus(1'b1, 1'b0, a, 16'($urandom));
      else if (kind < 9) applyStimulus(1'b0, 1'b1, a, 16'($urandom));
      else               applyStimulus(1'b1, 1'b1, a, 16'($urandom));
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
